// File: rtl/sfr_seq_pkg.sv
// Shared definitions for the SFR load sequencer: FSM state encoding and
// the bit-counter width helper used by the top and the leading-one encoder.
package sfr_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Counter width: one bit wider than needed to index SIZE bits, so the
    // counter can represent SIZE itself and never has to wrap.
    function automatic int cnt_width(input int size);
        return $clog2(size) + 1;
    endfunction

endpackage

// File: rtl/sfr_lead_one.sv
// Leading-one priority encoder: reports the index of the most significant
// set bit of data_i and flags an all-zero input. Only instantiated by
// sfr_load_seq when SFR_SEQ_SKIP_LZ_EN is defined.
module sfr_lead_one
    import sfr_seq_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0]            data_i,
    output logic [cnt_width(SIZE)-1:0] idx_o,
    output logic                       zero_o
);

    localparam int CW = cnt_width(SIZE);

    // Scan upward so the highest set bit is the last one to win.
    always_comb begin
        idx_o  = '0;
        zero_o = 1'b1;
        for (int i = 0; i < SIZE; i++) begin
            if (data_i[i]) begin
                idx_o  = CW'(i);
                zero_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/sfr_load_seq.sv
// SFR load sequencer: builds a captured word inside a downstream left-shift
// SFR (Q <= (Q + incr) << left, clr dominant) by clearing it, then feeding
// the word MSB-first as increments with a shift between bits.
// Optional build macro: SFR_SEQ_SKIP_LZ_EN -- start shifting at the leading
// one of the word instead of at bit SIZE-1 (an all-zero word skips SHIFT).
module sfr_load_seq
    import sfr_seq_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            in_valid,
    input  logic [SIZE-1:0] in_data,
    output logic            in_ready,
    output logic            sfr_clr,
    output logic            sfr_left,
    output logic            sfr_incr,
    output logic            done
);

    localparam int CW = cnt_width(SIZE);
    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;

    // cnt_q holds the bit index still to be fed (SIZE-1-j); it counts down
    // and SHIFT ends when it reaches its terminal value of zero.
    state_e            state_q, state_d;
    logic [SIZE-1:0]   word_q,  word_d;
    logic [CW-1:0]     cnt_q,   cnt_d;

    logic [CW-1:0]     start_idx;
    logic              start_zero;

`ifdef SFR_SEQ_SKIP_LZ_EN
    sfr_lead_one #(
        .SIZE (SIZE)
    ) u_lead_one (
        .data_i (word_q),
        .idx_o  (start_idx),
        .zero_o (start_zero)
    );
`else
    assign start_idx  = CW'(SIZE - 1);
    assign start_zero = 1'b0;
`endif

    // State, captured word and bit counter; clr returns everything to idle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            word_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic and Moore output decode from registered state only.
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        cnt_d    = cnt_q;
        in_ready = 1'b0;
        sfr_clr  = 1'b0;
        sfr_left = 1'b0;
        sfr_incr = 1'b0;
        done     = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                cnt_d    = '0;
                if (in_valid) begin
                    word_d  = in_data;
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                sfr_clr = 1'b1;
                cnt_d   = start_idx;
                state_d = start_zero ? DONE : SHIFT;
            end
            SHIFT: begin
                sfr_incr = word_q[cnt_q[IW-1:0]];
                // The last bit is added without shifting so the MSB never
                // falls off the top of the SFR.
                sfr_left = (cnt_q != '0);
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
